// File: rtl/fixed_point_matrix_mac_seq_pkg.sv
// Shared types and helpers for the sequential fixed-point matrix MAC engine.
//   mac_state_e : controller states IDLE -> MAC -> WRB -> (MAC | DONE) -> IDLE
//   mac_mode_e  : operation select (A*B, A*B+C, A^T*B, reserved)
//   acc_width() : accumulator width able to hold N full-precision products
package fixed_point_matrix_mac_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_WRB  = 2'd2,
    ST_DONE = 2'd3
  } mac_state_e;

  typedef enum logic [1:0] {
    MODE_AB   = 2'd0,
    MODE_ABC  = 2'd1,
    MODE_ATB  = 2'd2,
    MODE_RSVD = 2'd3
  } mac_mode_e;

  // 2W-bit products, N of them summed, plus one guard bit.
  function automatic int acc_width(input int w, input int n);
    return 2 * w + $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/fixed_point_matrix_mac_seq_lane.sv
// One MAC lane: accumulates full-precision signed products, then on write-back
// optionally adds the addend C (aligned to the product's fractional point),
// rounds half-up and saturates to W bits.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset (clears accumulator)
//   i_clr          : clear accumulator (write-back cycle)
//   i_acc_en       : add i_a*i_b into the accumulator
//   i_add_c        : include i_c in the rounded result
//   i_a, i_b, i_c  : signed Q(W-FRAC).FRAC operands
//   o_res          : rounded/saturated result of the current accumulator
//   o_clamped      : o_res was clamped to the W-bit range
module fixed_point_matrix_mac_seq_lane
  import fixed_point_matrix_mac_seq_pkg::*;
#(
  parameter int N    = 3,
  parameter int W    = 32,
  parameter int FRAC = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  input  logic                i_acc_en,
  input  logic                i_add_c,
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  input  logic signed [W-1:0] i_c,
  output logic signed [W-1:0] o_res,
  output logic                o_clamped
);

  localparam int AW = acc_width(W, N);
  // Two extra bits of headroom for the aligned addend and the rounding constant.
  localparam int SW = AW + 2;

  logic signed [AW-1:0]  r_acc;
  logic signed [2*W-1:0] w_prod;
  logic signed [SW-1:0]  w_sum;

  // Returns {clamped, value}: half-up rounding then clamp to signed W bits.
  function automatic logic [W:0] sat_round(input logic signed [SW-1:0] acc);
    logic signed [SW-1:0] t;
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    t  = (acc + (SW'(1) <<< (FRAC - 1))) >>> FRAC;
    hi = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    lo = ~hi;
    if (t > hi)      return {1'b1, hi[W-1:0]};
    else if (t < lo) return {1'b1, lo[W-1:0]};
    else             return {1'b0, t[W-1:0]};
  endfunction

  assign w_prod = (2*W)'(i_a) * (2*W)'(i_b);
  assign w_sum  = SW'(r_acc) + (i_add_c ? (SW'(i_c) <<< FRAC) : SW'(0));
  assign {o_clamped, o_res} = sat_round(w_sum);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      r_acc <= '0;
    else if (i_clr)    r_acc <= '0;
    else if (i_acc_en) r_acc <= r_acc + AW'(w_prod);
  end

endmodule

// File: rtl/fixed_point_matrix_mac_seq.sv
// Sequential fixed-point matrix multiply/accumulate engine: R = op(A)*B (+C)
// in signed Q(W-FRAC).FRAC, LANES outputs computed in parallel per group.
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   i_start  : request, sampled only in IDLE
//   i_mode   : 0 A*B, 1 A*B+C, 2 A^T*B (M==N), 3 reserved (err)
//   i_a/b/c  : operand matrices, packed [row][col][bit]
//   o_r      : result matrix, held until the next accepted start
//   o_busy   : operation in progress (MAC/WRB)
//   o_done   : one-cycle completion pulse
//   o_ovf    : sticky, some element saturated during the last operation
//   o_err    : pulses with o_done for the reserved mode
module fixed_point_matrix_mac_seq
  import fixed_point_matrix_mac_seq_pkg::*;
#(
  parameter int M     = 3,
  parameter int N     = 3,
  parameter int P     = 3,
  parameter int W     = 32,
  parameter int FRAC  = 16,
  parameter int LANES = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic [1:0]                   i_mode,
  input  logic [M-1:0][N-1:0][W-1:0]   i_a,
  input  logic [N-1:0][P-1:0][W-1:0]   i_b,
  input  logic [M-1:0][P-1:0][W-1:0]   i_c,
  output logic [M-1:0][P-1:0][W-1:0]   o_r,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_ovf,
  output logic                         o_err
);

  localparam int G  = M * P / LANES;
  localparam int GW = $clog2(G + 1);
  localparam int KW = $clog2(N + 1);

  if ((P % LANES) != 0) begin : g_bad_lanes
    $error("LANES (%0d) must divide P (%0d)", LANES, P);
  end

  mac_state_e r_state;
  mac_state_e w_next;
  logic       w_accept;
  logic       w_acc_en;
  logic       w_wrb;

  logic [GW-1:0] r_g;
  logic [KW-1:0] r_k;
  mac_mode_e     r_mode;
  logic          r_ovf;

  logic [M-1:0][N-1:0][W-1:0] r_a;
  logic [N-1:0][P-1:0][W-1:0] r_b;
  logic [M-1:0][P-1:0][W-1:0] r_c;
  logic [M-1:0][P-1:0][W-1:0] r_r;

  int                w_i     [LANES];
  int                w_j     [LANES];
  logic signed [W-1:0] w_opa [LANES];
  logic signed [W-1:0] w_opb [LANES];
  logic signed [W-1:0] w_opc [LANES];
  logic signed [W-1:0] w_res [LANES];
  logic [LANES-1:0]  w_clamped;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_acc_en = 1'b0;
    w_wrb    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept = 1'b1;
          w_next   = (i_mode == MODE_RSVD) ? ST_DONE : ST_MAC;
        end
      end
      ST_MAC: begin
        w_acc_en = 1'b1;
        if (r_k == KW'(N - 1)) w_next = ST_WRB;
      end
      ST_WRB: begin
        w_wrb  = 1'b1;
        w_next = (r_g == GW'(G - 1)) ? ST_DONE : ST_MAC;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Operands are captured on accept so the inputs are free to change mid-run.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_a <= i_a;
      r_b <= i_b;
      r_c <= i_c;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_k    <= '0;
      r_g    <= '0;
      r_mode <= MODE_AB;
      r_ovf  <= 1'b0;
      r_r    <= '0;
    end else begin
      if (w_accept) begin
        r_k    <= '0;
        r_g    <= '0;
        r_mode <= mac_mode_e'(i_mode);
        // The reserved mode leaves the previous result and its flag untouched.
        if (i_mode != MODE_RSVD) r_ovf <= 1'b0;
      end
      if (w_acc_en) r_k <= (r_k == KW'(N - 1)) ? '0 : r_k + 1'b1;
      if (w_wrb) begin
        r_g <= r_g + 1'b1;
        if (|w_clamped) r_ovf <= 1'b1;
        for (int l = 0; l < LANES; l++)
          for (int ii = 0; ii < M; ii++)
            for (int jj = 0; jj < P; jj++)
              if (ii == w_i[l] && jj == w_j[l]) r_r[ii][jj] <= w_res[l];
      end
    end
  end

  // Lane l of group g owns output element idx = g*LANES + l (row-major).
  // Operands are picked with constant-index loops to keep the muxes explicit.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_i[l]   = (int'(r_g) * LANES + l) / P;
      w_j[l]   = (int'(r_g) * LANES + l) % P;
      w_opa[l] = '0;
      w_opb[l] = '0;
      w_opc[l] = '0;
      for (int ra = 0; ra < M; ra++)
        for (int ca = 0; ca < N; ca++) begin
          if (r_mode == MODE_ATB) begin
            if (ra == int'(r_k) && ca == w_i[l]) w_opa[l] = r_a[ra][ca];
          end else begin
            if (ra == w_i[l] && ca == int'(r_k)) w_opa[l] = r_a[ra][ca];
          end
        end
      for (int rb = 0; rb < N; rb++)
        for (int cb = 0; cb < P; cb++)
          if (rb == int'(r_k) && cb == w_j[l]) w_opb[l] = r_b[rb][cb];
      for (int rc = 0; rc < M; rc++)
        for (int cc = 0; cc < P; cc++)
          if (rc == w_i[l] && cc == w_j[l]) w_opc[l] = r_c[rc][cc];
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fixed_point_matrix_mac_seq_lane #(
      .N    (N),
      .W    (W),
      .FRAC (FRAC)
    ) u_lane (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clr     (w_wrb),
      .i_acc_en  (w_acc_en),
      .i_add_c   (r_mode == MODE_ABC),
      .i_a       (w_opa[l]),
      .i_b       (w_opb[l]),
      .i_c       (w_opc[l]),
      .o_res     (w_res[l]),
      .o_clamped (w_clamped[l])
    );
  end

  assign o_r    = r_r;
  assign o_busy = (r_state == ST_MAC) || (r_state == ST_WRB);
  assign o_done = (r_state == ST_DONE);
  assign o_err  = (r_state == ST_DONE) && (r_mode == MODE_RSVD);
  assign o_ovf  = r_ovf;

endmodule
